acia_rx: RTL

- Serial receiver core for the 6551-compatible ACIA at 0x8000. It deserialises the `rxd` pin and presents the result to the CPU-side register file.
- Frame format is fixed at 8 data bits, optional parity and 1 stop bit, with 16x oversampling from an internal prescaler.
- It is the receive counterpart to the ACIA transmit path that drives `txd`. Status bits map onto the 6551 status register.

---
 rtl/acia_pkg.sv | 30 +++
 rtl/acia_rx_if.sv | 24 ++
 rtl/acia_baud_tick.sv | 32 +++
 rtl/acia_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// Shared ACIA definitions: receive FSM encoding, oversampling constants,
// 6551 status register bit positions and the parity check helper.
package acia_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // 6551 status register bit positions
    localparam int SR_PE   = 0;
    localparam int SR_FE   = 1;
    localparam int SR_OVR  = 2;
    localparam int SR_RDRF = 3;

    // High when the received parity bit does not produce the selected parity.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       par_bit,
                                             input logic       odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/acia_rx_if.sv
// CPU-side register-file connection of the ACIA receiver.
// master = register file / CPU side, slave = receiver core.
interface acia_rx_if;
    logic       rx_en;
    logic       parity_en;
    logic       parity_odd;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rdrf;
    logic       ovr;
    logic       fe;
    logic       pe;
    logic       rts_n;

    modport master (
        output rx_en, parity_en, parity_odd, rd_ack,
        input  rx_data, rdrf, ovr, fe, pe, rts_n
    );

    modport slave (
        input  rx_en, parity_en, parity_odd, rd_ack,
        output rx_data, rdrf, ovr, fe, pe, rts_n
    );
endinterface

// File: rtl/acia_baud_tick.sv
// Free-running prescaler producing a one-cycle tick every DIVISOR clocks.
// Shared by the receive and transmit paths; only reset clears it.
module acia_baud_tick #(
    parameter int unsigned DIVISOR = 26
) (
    input  logic clk,
    input  logic resb,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(DIVISOR - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = (cnt_q == TERM);

    // Wrap to zero on terminal count, otherwise count up.
    always_comb begin
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acia_rx.sv
// 6551-compatible ACIA receive core: 8 data bits, optional parity, 1 stop
// bit, 16x oversampling. Loads the received byte and its error flags into
// the CPU-visible data/status registers and drives RTS flow control.
module acia_rx
    import acia_pkg::*;
#(
    parameter int unsigned DIVISOR     = 26,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     resb,
    input  logic     rxd,
    acia_rx_if.slave bus
);

    localparam logic [3:0] SAMP_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   rxd_prev_q, rxd_prev_d;
    logic                   rxd_s;
    logic                   fall;
    logic                   bit_done;
    logic                   load;

    rx_state_e              state_q,    state_d;
    logic [3:0]             samp_cnt_q, samp_cnt_d;
    logic [2:0]             bit_idx_q,  bit_idx_d;
    logic [7:0]             shift_q,    shift_d;
    logic                   par_err_q,  par_err_d;
    logic [7:0]             rx_data_q,  rx_data_d;
    logic [3:0]             flags_q,    flags_d;
    logic                   rts_n_q,    rts_n_d;

    acia_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk  (clk),
        .resb (resb),
        .tick (tick)
    );

    // Synchroniser shift and start-edge detection on the synchronised line.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
        rxd_s      = sync_q[SYNC_STAGES-1];
        rxd_prev_d = rxd_s;
        fall       = rxd_prev_q & ~rxd_s;
        bit_done   = tick && (samp_cnt_q == SAMP_LAST);
    end

    // Synchroniser registers idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            sync_q     <= '1;
            rxd_prev_q <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; disabling the receiver aborts any frame in progress.
    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && !bus.rx_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_en && fall) state_d = ST_START;
                end
                ST_START: begin
                    if (tick && samp_cnt_q == SAMP_MID) begin
                        state_d = rxd_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done && bit_idx_q == 3'd7) begin
                        state_d = bus.parity_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) state_d = ST_STOP;
                end
                ST_STOP: begin
                    // A low stop bit is a break: wait for the line to recover.
                    if (bit_done) state_d = rxd_s ? ST_IDLE : ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    if (rxd_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: sample counting, deserialising and the register load.
    always_comb begin
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        rx_data_d  = rx_data_q;
        flags_d    = flags_q;
        load       = 1'b0;

        if (state_d != state_q) begin
            samp_cnt_d = 4'd0;
        end else if (tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
        end

        if (state_q == ST_START && state_d == ST_DATA) begin
            bit_idx_d = 3'd0;
            par_err_d = 1'b0;
        end

        if (state_q == ST_DATA && bit_done) begin
            shift_d[bit_idx_q] = rxd_s;
            bit_idx_d          = bit_idx_q + 3'd1;
        end

        if (state_q == ST_PARITY && bit_done) begin
            par_err_d = parity_mismatch(shift_q, rxd_s, bus.parity_odd);
        end

        load = (state_q == ST_STOP) && bit_done && bus.rx_en;

        // A load always beats a coincident read; otherwise a read clears status.
        if (load) begin
            if (!flags_q[SR_RDRF] || bus.rd_ack) begin
                rx_data_d         = shift_q;
                flags_d[SR_RDRF]  = 1'b1;
                flags_d[SR_FE]    = ~rxd_s;
                flags_d[SR_PE]    = par_err_q;
                if (bus.rd_ack) flags_d[SR_OVR] = 1'b0;
            end else begin
                flags_d[SR_OVR] = 1'b1;
            end
        end else if (bus.rd_ack) begin
            flags_d = 4'b0000;
        end

        rts_n_d = ~(~flags_q[SR_RDRF] & bus.rx_en);
    end

    // Frame datapath and CPU-visible data/status registers.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            samp_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_err_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            flags_q    <= 4'b0000;
            rts_n_q    <= 1'b1;
        end else begin
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            rx_data_q  <= rx_data_d;
            flags_q    <= flags_d;
            rts_n_q    <= rts_n_d;
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdrf    = flags_q[SR_RDRF];
    assign bus.ovr     = flags_q[SR_OVR];
    assign bus.fe      = flags_q[SR_FE];
    assign bus.pe      = flags_q[SR_PE];
    assign bus.rts_n   = rts_n_q;

endmodule
